// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue: issues sequential fetch requests, collects
// returned words in request order, and discards responses left over from a redirect.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   r_fpc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_fill;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_unfilled;
  logic [CW-1:0] r_discard;
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_inst [DEPTH];

  logic          w_push;
  logic          w_fill;
  logic          w_drop;
  logic          w_pop;
  logic [CW:0]   w_budget;
  logic [CW:0]   w_outstanding;
  logic [CW:0]   w_flushDiscard;

  // Discarded responses still occupy memory-side slots, so they count against the request budget.
  assign w_budget      = {1'b0, r_count} + {1'b0, r_discard};
  assign w_outstanding = {1'b0, r_unfilled} + {1'b0, r_discard};

  assign inst_req  = !reset && !flush_i && (r_count < DEPTH_C) && (w_budget < {1'b0, DEPTH_C});
  assign inst_addr = r_fpc;

  assign w_push = inst_req && inst_addr_ok;
  assign w_drop = inst_data_ok && !flush_i && (r_discard != '0);
  assign w_fill = inst_data_ok && !flush_i && (r_discard == '0) && (r_unfilled != '0);

  // The head is filled exactly when some occupied slot is not still waiting for data.
  assign valid_o = !reset && (r_count != r_unfilled);
  assign pc_o    = r_pc[r_head];
  assign inst_o  = r_inst[r_head];
  assign w_pop   = valid_o && ready_i && !flush_i;

  // A response arriving in the flush cycle retires one old-stream request, whichever kind it was.
  assign w_flushDiscard = w_outstanding - {{CW{1'b0}}, (inst_data_ok && (w_outstanding != '0))};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc      <= RESET_PC;
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_discard  <= '0;
    end else if (flush_i) begin
      r_fpc      <= flush_pc_i;
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_discard  <= w_flushDiscard[CW-1:0];
    end else begin
      if (w_push) begin
        r_fpc  <= r_fpc + 32'd4;
        r_tail <= r_tail + PW'(1);
      end
      if (w_fill) begin
        r_fill <= r_fill + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_unfilled <= r_unfilled + CW'(w_push) - CW'(w_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail] <= r_fpc;
    end
    if (w_fill) begin
      r_inst[r_fill] <= inst_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed and randomized-stall bench for inst_fetch_queue with an in-order
// single-latency memory model.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] memQ [$];
  logic [31:0] expQ [$];

  logic        obsReq;
  logic [31:0] obsAddr;
  logic        obsValid;
  logic [31:0] obsPc;
  logic [31:0] obsInst;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hbfc00000)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5ac3c3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample just after, then let the memory model see the rising edge.
  task automatic applyStimulus(input logic addrOk, input logic dataEn, input logic rdy,
                               input logic fl, input logic [31:0] flPc);
    inst_addr_ok = addrOk;
    ready_i      = rdy;
    flush_i      = fl;
    flush_pc_i   = flPc;
    if (dataEn && memQ.size() > 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = instOf(memQ[0]);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0;
    end
    #1;
    obsReq   = inst_req;
    obsAddr  = inst_addr;
    obsValid = valid_o;
    obsPc    = pc_o;
    obsInst  = inst_o;
    @(posedge clk);
    if (inst_data_ok) void'(memQ.pop_front());
    if (obsReq && addrOk) begin
      memQ.push_back(obsAddr);
      expQ.push_back(obsAddr);
    end
    @(negedge clk);
  endtask

  task automatic drainAndReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    memQ.delete();
    expQ.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        seenValid;
    logic        found;
    logic        prevHold;
    logic [31:0] prevPc;
    logic [31:0] prevInst;
    logic [31:0] expPc;
    logic        aok, den, rdy;
    int          accepted;
    logic        vHist [6];
    logic [31:0] pHist [6];
    logic [31:0] iHist [6];

    reset = 1'b1; flush_i = 1'b0; flush_pc_i = '0; inst_addr_ok = 1'b0;
    inst_rdata = '0; inst_data_ok = 1'b0; ready_i = 1'b0;
    @(negedge clk);

    // Reset state and release
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("resetReq", obsReq, 1'b0);
    checkOutput("resetValid", obsValid, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("releaseReq", obsReq, 1'b1);
    checkOutput("releaseAddr", obsAddr, 32'hbfc00000);
    checkOutput("releaseValid", obsValid, 1'b0);

    // Streaming with 1-cycle memory and ready held high
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      vHist[c] = obsValid; pHist[c] = obsPc; iHist[c] = obsInst;
    end
    checkOutput("streamLatency", vHist[1], 1'b0);
    checkOutput("streamValid0", vHist[2], 1'b1);
    checkOutput("streamPc0", pHist[2], 32'hbfc00000);
    checkOutput("streamInst0", iHist[2], instOf(32'hbfc00000));
    checkOutput("streamValid1", vHist[3], 1'b1);
    checkOutput("streamPc1", pHist[3], 32'hbfc00004);
    checkOutput("streamValid2", vHist[4], 1'b1);
    checkOutput("streamPc2", pHist[4], 32'hbfc00008);

    // Full queue with decode stalled
    drainAndReset();
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (obsReq) accepted++;
    end
    checkOutput("fullAccepted", accepted, 4);
    checkOutput("fullReqLow", obsReq, 1'b0);
    checkOutput("fullHoldPc", obsPc, 32'hbfc00000);
    checkOutput("fullHoldInst", obsInst, instOf(32'hbfc00000));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("popValid", obsValid, 1'b1);
    checkOutput("popSameCycleReq", obsReq, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("popNextReq", obsReq, 1'b1);
    checkOutput("popNextAddr", obsAddr, 32'hbfc00010);
    checkOutput("popNextPc", obsPc, 32'hbfc00004);

    // Flush with three requests outstanding
    drainAndReset();
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h80000180);
    checkOutput("flushReq", obsReq, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (c == 0) checkOutput("flushNewAddr", obsAddr, 32'h80000180);
      if (obsValid) begin
        found = 1'b1;
        checkOutput("flushFirstPc", obsPc, 32'h80000180);
        checkOutput("flushFirstInst", obsInst, instOf(32'h80000180));
      end
    end
    checkOutput("flushFirstValid", found, 1'b1);

    // Flush coinciding with a response, two requests outstanding
    drainAndReset();
    for (int c = 0; c < 2; c++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h80000200);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (obsValid) begin
        found = 1'b1;
        checkOutput("flushDataPc", obsPc, 32'h80000200);
        checkOutput("flushDataInst", obsInst, instOf(32'h80000200));
      end
    end
    checkOutput("flushDataValid", found, 1'b1);

    // Reset with requests in flight; stray responses must not surface
    drainAndReset();
    for (int c = 0; c < 2; c++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("midResetReq", obsReq, 1'b0);
    reset = 1'b0;
    seenValid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      if (c == 0) begin
        checkOutput("midResetValid", obsValid, 1'b0);
        checkOutput("midResetAddr", obsAddr, 32'hbfc00000);
      end
      if (obsValid) seenValid = 1'b1;
    end
    checkOutput("strayNoValid", seenValid, 1'b0);
    checkOutput("strayAddr", inst_addr, 32'hbfc00000);

    // Random handshake stalls against the in-order memory model
    drainAndReset();
    prevHold = 1'b0; prevPc = '0; prevInst = '0;
    for (int c = 0; c < 416; c++) begin
      if (c < 400) begin
        aok = ($urandom_range(0, 3) != 0);
        den = ($urandom_range(0, 2) != 0);
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        aok = 1'b0; den = 1'b1; rdy = 1'b1;
      end
      applyStimulus(aok, den, rdy, 1'b0, 32'h0);
      if (prevHold && obsValid) begin
        checkOutput("holdPc", obsPc, prevPc);
        checkOutput("holdInst", obsInst, prevInst);
      end else if (prevHold) begin
        checkOutput("holdValid", obsValid, 1'b1);
      end
      if (obsValid && rdy) begin
        if (expQ.size() == 0) begin
          checkOutput("extraDelivery", 1'b1, 1'b0);
        end else begin
          expPc = expQ.pop_front();
          checkOutput("orderPc", obsPc, expPc);
          checkOutput("orderInst", obsInst, instOf(expPc));
        end
      end
      prevHold = obsValid && !rdy;
      prevPc   = obsPc;
      prevInst = obsInst;
    end
    checkOutput("noLoss", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
